event_log_buffer: RTL and testbench

// Parametrised trace logger for the host/network datapath: records timestamped status/data snapshots into a circular buffer.
// Arm/trigger control with post-trigger capture; stop-when-full or wrap mode; overflow accounting; 1-cycle random-access readback.

---
 rtl/event_log_buffer_if.sv | 13 +
 rtl/event_log_buffer.sv | 133 +++++++++++++
 tb/tb_event_log_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_log_buffer_if.sv
// rtl/event_log_buffer_if.sv - random-access readback bus of the event log buffer
interface event_log_buffer_if #(
  parameter int AW      = 8,
  parameter int ENTRY_W = 92
);
  logic               rd_req;
  logic [AW-1:0]      rd_idx;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;

  modport master (output rd_req, output rd_idx, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_idx, output rd_valid, output rd_data);
endinterface

// File: rtl/event_log_buffer.sv
// rtl/event_log_buffer.sv - timestamped circular trace buffer with arm/trigger/post-capture
module event_log_buffer #(
  parameter int DATA_SIZE = 32,
  parameter int TAG_SIZE  = 8,
  parameter int DEPTH     = 256,
  parameter int TS_W      = 16,
  parameter int WRAP_MODE = 1,
  parameter int POST_TRIG = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int ENTRY_W  = 4 + TS_W + 2*DATA_SIZE + TAG_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          log_all,
  input  logic                          parity_error_in,
  input  logic                          host_data_ready_in,
  input  logic                          network_data_ready_in,
  input  logic                          network_ack_in,
  input  logic [DATA_SIZE-1:0]          host_data_in,
  input  logic [DATA_SIZE+TAG_SIZE-1:0] ndt_in,
  event_log_buffer_if.slave             rd_bus,
  output logic                          busy,
  output logic                          done,
  output logic [AW:0]                   count,
  output logic [AW-1:0]                 trig_idx,
  output logic                          triggered,
  output logic [15:0]                   dropped
);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_TRIG - 1);

  state_t             state;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      post_cnt;
  logic [AW-1:0]      oldest;
  logic [AW-1:0]      rd_addr;
  logic [TS_W-1:0]    ts;
  logic [ENTRY_W-1:0] entry;
  logic               recording;
  logic               store;
  logic               full;

  assign recording = (state == ARMED) || (state == POST);
  assign store     = recording && !arm &&
                     (log_all | parity_error_in | host_data_ready_in |
                      network_data_ready_in | network_ack_in);
  assign full      = (count == DEPTH_CNT);
  assign entry     = {parity_error_in, host_data_ready_in, network_data_ready_in,
                      network_ack_in, ts, host_data_in, ndt_in};
  // Once the buffer has wrapped the next slot to be written holds the oldest entry.
  assign oldest    = full ? wr_ptr : '0;
  assign rd_addr   = oldest + rd_bus.rd_idx;

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bus.rd_valid <= 1'b0;
      rd_bus.rd_data  <= '0;
    end else begin
      rd_bus.rd_valid <= rd_bus.rd_req;
      if (rd_bus.rd_req)
        rd_bus.rd_data <= ({1'b0, rd_bus.rd_idx} >= count) ? '0 : mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      ts        <= '0;
      post_cnt  <= '0;
      dropped   <= '0;
      triggered <= 1'b0;
      trig_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (arm) begin
      state     <= ARMED;
      wr_ptr    <= '0;
      count     <= '0;
      ts        <= '0;
      post_cnt  <= '0;
      dropped   <= '0;
      triggered <= 1'b0;
      trig_idx  <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      if (recording) ts <= ts + 1'b1;
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!full) count <= count + 1'b1;
        else if (dropped != 16'hFFFF) dropped <= dropped + 1'b1;
        // An overwrite moves the oldest entry forward, so the trigger slides toward index 0.
        if (full && triggered && (trig_idx != '0)) trig_idx <= trig_idx - 1'b1;
        if ((state == ARMED) && parity_error_in) begin
          triggered <= 1'b1;
          trig_idx  <= full ? '1 : count[AW-1:0];
          post_cnt  <= '0;
          if (POST_TRIG == 0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= POST;
          end
        end else if (state == POST) begin
          post_cnt <= post_cnt + 1'b1;
          if (post_cnt == POST_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        if ((WRAP_MODE == 0) && (count == DEPTH_CNT - 1'b1)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_event_log_buffer.sv
// tb/tb_event_log_buffer.sv - bench for event_log_buffer: wrap and stop instances against a store-history model
module tb_event_log_buffer;
  localparam int DS = 8, TG = 4, DP = 8, TSW = 8, PT = 3, AW = 3, EW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, arm, log_all, par, hrdy, nrdy, nack, rd_req;
  logic [DS-1:0]    hdata;
  logic [DS+TG-1:0] ndt;
  logic [AW-1:0]    rd_idx;

  logic          o_busy [2], o_done [2], o_trig [2], o_rv [2];
  logic [AW:0]   o_count [2];
  logic [AW-1:0] o_tidx [2];
  logic [15:0]   o_drop [2];
  logic [EW-1:0] o_rd [2];

  event_log_buffer_if #(.AW(AW), .ENTRY_W(EW)) rb0 ();
  event_log_buffer_if #(.AW(AW), .ENTRY_W(EW)) rb1 ();
  assign rb0.rd_req = rd_req;
  assign rb0.rd_idx = rd_idx;
  assign rb1.rd_req = rd_req;
  assign rb1.rd_idx = rd_idx;
  assign o_rv[0] = rb0.rd_valid;
  assign o_rv[1] = rb1.rd_valid;
  assign o_rd[0] = rb0.rd_data;
  assign o_rd[1] = rb1.rd_data;

  event_log_buffer #(.DATA_SIZE(DS), .TAG_SIZE(TG), .DEPTH(DP), .TS_W(TSW), .WRAP_MODE(1), .POST_TRIG(PT)) dut_wrap (
    .clk(clk), .reset(reset), .arm(arm), .log_all(log_all), .parity_error_in(par),
    .host_data_ready_in(hrdy), .network_data_ready_in(nrdy), .network_ack_in(nack),
    .host_data_in(hdata), .ndt_in(ndt), .rd_bus(rb0), .busy(o_busy[0]), .done(o_done[0]),
    .count(o_count[0]), .trig_idx(o_tidx[0]), .triggered(o_trig[0]), .dropped(o_drop[0]));

  event_log_buffer #(.DATA_SIZE(DS), .TAG_SIZE(TG), .DEPTH(DP), .TS_W(TSW), .WRAP_MODE(0), .POST_TRIG(PT)) dut_stop (
    .clk(clk), .reset(reset), .arm(arm), .log_all(log_all), .parity_error_in(par),
    .host_data_ready_in(hrdy), .network_data_ready_in(nrdy), .network_ack_in(nack),
    .host_data_in(hdata), .ndt_in(ndt), .rd_bus(rb1), .busy(o_busy[1]), .done(o_done[1]),
    .count(o_count[1]), .trig_idx(o_tidx[1]), .triggered(o_trig[1]), .dropped(o_drop[1]));

  // Model: every run is the list of entries stored since arm; the buffer shows its last DP.
  // Phase codes: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 finished.
  int            m_phase [2], m_n [2], m_tseq [2], m_post [2];
  logic [TSW-1:0] m_ts [2];
  logic          m_trig [2];
  logic [EW-1:0] hist [2][1024];
  logic          e_rv [2];
  logic [EW-1:0] e_rd [2];
  int            checks = 0, failures = 0;

  function automatic int m_size(int k);
    return (m_n[k] > DP) ? DP : m_n[k];
  endfunction

  function automatic logic [EW-1:0] m_read(int k, int idx);
    int sz = m_size(k);
    if (idx < sz) return hist[k][(m_n[k] - sz + idx) % 1024];
    return '0;
  endfunction

  function automatic logic [25:0] m_status(int k);
    int sz   = m_size(k);
    int drop = (k == 0) ? m_n[k] - sz : 0;
    int tidx = m_trig[k] ? m_tseq[k] - (m_n[k] - sz) : 0;
    if (drop > 65535) drop = 65535;
    return {(m_phase[k] == 1) || (m_phase[k] == 2), m_phase[k] == 3, (AW+1)'(sz),
            AW'(tidx), m_trig[k], 16'(drop)};
  endfunction

  task automatic tick();
    logic [EW-1:0] entry;
    for (int k = 0; k < 2; k++) begin
      e_rv[k] = !reset && rd_req;
      if (reset) e_rd[k] = '0;
      else if (rd_req) e_rd[k] = m_read(k, int'(rd_idx));
      entry = {par, hrdy, nrdy, nack, m_ts[k], hdata, ndt};
      if (reset) begin
        m_phase[k] = 0; m_n[k] = 0; m_ts[k] = '0; m_trig[k] = 1'b0; m_tseq[k] = 0;
      end else if (arm) begin
        m_phase[k] = 1; m_n[k] = 0; m_ts[k] = '0; m_trig[k] = 1'b0; m_tseq[k] = 0;
      end else if (m_phase[k] == 1 || m_phase[k] == 2) begin
        m_ts[k] = m_ts[k] + 1'b1;
        if (log_all | par | hrdy | nrdy | nack) begin
          hist[k][m_n[k] % 1024] = entry;
          m_n[k]++;
          if (m_phase[k] == 1 && par) begin
            m_trig[k] = 1'b1; m_tseq[k] = m_n[k] - 1; m_post[k] = PT;
            m_phase[k] = (PT == 0) ? 3 : 2;
          end else if (m_phase[k] == 2) begin
            m_post[k]--;
            if (m_post[k] == 0) m_phase[k] = 3;
          end
          if (k == 1 && m_n[k] == DP) m_phase[k] = 3;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; log_all = 0; par = 0; hrdy = 0; nrdy = 0; nack = 0; rd_req = 0; rd_idx = '0;
  endtask

  task automatic do_read(int idx);
    rd_req = 1; rd_idx = AW'(idx);
    tick();
    rd_req = 0;
  endtask

  task automatic pulse_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1; rd_req = 1;
    tick(); tick();
    reset = 0; rd_req = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_busy[k], o_done[k], o_count[k], o_tidx[k], o_trig[k], o_drop[k], o_rv[k], o_rd[k]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got busy=%0b done=%0b count=%0d tidx=%0d trig=%0b drop=%0d rv=%0b rd=%0h required all 0",
                 k, o_busy[k], o_done[k], o_count[k], o_tidx[k], o_trig[k], o_drop[k], o_rv[k], o_rd[k]);
      end
    end
  endtask

  task automatic test_sparse();
    logic [TSW-1:0] prev_ts;
    idle_inputs(); pulse_arm();
    for (int i = 0; i < 10; i++) begin
      hrdy = (i % 2 == 0); hdata = DS'($urandom); ndt = (DS+TG)'($urandom);
      tick();
    end
    hrdy = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_count[k] !== 4'd5 || o_done[k] !== 1'b0 || o_busy[k] !== 1'b1) begin
        failures++;
        $display("FAIL sparse_status dut%0d got count=%0d done=%0b busy=%0b required 5/0/1", k, o_count[k], o_done[k], o_busy[k]);
      end
    end
    prev_ts = '0;
    for (int i = 0; i < 6; i++) begin
      do_read(i);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_rv[k] !== 1'b1 || o_rd[k] !== e_rd[k]) begin
          failures++;
          $display("FAIL sparse_read dut%0d idx%0d got rv=%0b data=%0h required 1/%0h", k, i, o_rv[k], o_rd[k], e_rd[k]);
        end
      end
      if (i > 0 && i < 5) begin
        checks++;
        if (o_rd[0][27:20] <= prev_ts) begin
          failures++;
          $display("FAIL sparse_ts_order idx%0d got ts=%0d required above %0d", i, o_rd[0][27:20], prev_ts);
        end
      end
      prev_ts = o_rd[0][27:20];
    end
  endtask

  task automatic test_wrap_stop();
    idle_inputs(); pulse_arm();
    log_all = 1;
    for (int i = 0; i < 12; i++) begin
      hdata = DS'($urandom); ndt = (DS+TG)'($urandom);
      tick();
      checks++;
      if (o_done[1] !== (i >= 7)) begin
        failures++;
        $display("FAIL stop_done_edge store%0d got done=%0b required %0b", i + 1, o_done[1], i >= 7);
      end
    end
    log_all = 0;
    checks++;
    if (o_count[0] !== 4'd8 || o_drop[0] !== 16'd4 || o_done[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_status got count=%0d dropped=%0d done=%0b required 8/4/0", o_count[0], o_drop[0], o_done[0]);
    end
    checks++;
    if (o_count[1] !== 4'd8 || o_drop[1] !== 16'd0) begin
      failures++;
      $display("FAIL stop_status got count=%0d dropped=%0d required 8/0", o_count[1], o_drop[1]);
    end
    do_read(0);
    checks++;
    if (o_rv[0] !== 1'b1 || o_rd[0] !== hist[0][4]) begin
      failures++;
      $display("FAIL wrap_oldest got rv=%0b data=%0h required 1/%0h", o_rv[0], o_rd[0], hist[0][4]);
    end
    checks++;
    if (o_rd[1] !== hist[1][0]) begin
      failures++;
      $display("FAIL stop_oldest got data=%0h required %0h", o_rd[1], hist[1][0]);
    end
    do_read(7);
    checks++;
    if (o_rd[0] !== hist[0][11] || o_rd[1] !== hist[1][7]) begin
      failures++;
      $display("FAIL newest_read got %0h/%0h required %0h/%0h", o_rd[0], o_rd[1], hist[0][11], hist[1][7]);
    end
  endtask

  task automatic test_trigger();
    idle_inputs(); pulse_arm();
    log_all = 1;
    for (int i = 0; i < 10; i++) begin
      par = (i == 3); hdata = DS'($urandom); ndt = (DS+TG)'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_done[k] !== (i >= 6)) begin
          failures++;
          $display("FAIL trig_done_edge dut%0d cycle%0d got done=%0b required %0b", k, i, o_done[k], i >= 6);
        end
      end
    end
    par = 0; log_all = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_count[k] !== 4'd7 || o_tidx[k] !== 3'd3 || o_trig[k] !== 1'b1) begin
        failures++;
        $display("FAIL trig_status dut%0d got count=%0d trig_idx=%0d triggered=%0b required 7/3/1", k, o_count[k], o_tidx[k], o_trig[k]);
      end
    end
    do_read(3);
    checks++;
    if (o_rd[0][31] !== 1'b1 || o_rd[0] !== hist[0][3]) begin
      failures++;
      $display("FAIL trig_entry got %0h required %0h with parity set", o_rd[0], hist[0][3]);
    end
  endtask

  task automatic test_arm_during_post();
    idle_inputs(); pulse_arm();
    log_all = 1; par = 1; tick();
    par = 0; tick();
    log_all = 0; pulse_arm();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_count[k] !== '0 || o_trig[k] !== 1'b0 || o_busy[k] !== 1'b1 || o_done[k] !== 1'b0) begin
        failures++;
        $display("FAIL rearm_status dut%0d got count=%0d trig=%0b busy=%0b done=%0b required 0/0/1/0", k, o_count[k], o_trig[k], o_busy[k], o_done[k]);
      end
    end
    do_read(0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_rv[k] !== 1'b1 || o_rd[k] !== '0) begin
        failures++;
        $display("FAIL rearm_read dut%0d got rv=%0b data=%0h required 1/0", k, o_rv[k], o_rd[k]);
      end
    end
  endtask

  task automatic test_reset_armed();
    idle_inputs(); pulse_arm();
    log_all = 1;
    repeat (6) tick();
    checks++;
    if (o_count[0] !== 4'd6) begin
      failures++;
      $display("FAIL pre_reset_count got %0d required 6", o_count[0]);
    end
    reset = 1; rd_req = 1; tick();
    reset = 0; rd_req = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_busy[k], o_done[k], o_count[k], o_tidx[k], o_trig[k], o_drop[k], o_rv[k]} !== '0) begin
        failures++;
        $display("FAIL armed_reset dut%0d got busy=%0b count=%0d rv=%0b required 0", k, o_busy[k], o_count[k], o_rv[k]);
      end
    end
    tick();
    log_all = 0;
    checks++;
    if (o_count[0] !== '0 || o_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_store got count=%0d busy=%0b required 0/0", o_count[0], o_busy[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      arm     = ($urandom_range(0, 29) == 0);
      log_all = ($urandom_range(0, 3) == 0);
      par     = ($urandom_range(0, 9) == 0);
      hrdy    = ($urandom_range(0, 5) == 0);
      nrdy    = ($urandom_range(0, 7) == 0);
      nack    = ($urandom_range(0, 7) == 0);
      hdata   = DS'($urandom);
      ndt     = (DS+TG)'($urandom);
      rd_req  = $urandom_range(0, 1) == 1;
      rd_idx  = AW'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({o_busy[k], o_done[k], o_count[k], o_tidx[k], o_trig[k], o_drop[k]} !== m_status(k)) begin
          failures++;
          $display("FAIL rnd_status dut%0d cyc%0d got {busy,done,count,tidx,trig,drop}=%0h required %0h",
                   k, c, {o_busy[k], o_done[k], o_count[k], o_tidx[k], o_trig[k], o_drop[k]}, m_status(k));
        end
        checks++;
        if (o_rv[k] !== e_rv[k] || (e_rv[k] && o_rd[k] !== e_rd[k])) begin
          failures++;
          $display("FAIL rnd_read dut%0d cyc%0d got rv=%0b data=%0h required %0b/%0h", k, c, o_rv[k], o_rd[k], e_rv[k], e_rd[k]);
        end
      end
    end
    idle_inputs(); reset = 0;
  endtask

  initial begin
    reset = 0; hdata = '0; ndt = '0;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_n[k] = 0; m_ts[k] = '0; m_trig[k] = 1'b0; m_tseq[k] = 0; m_post[k] = 0;
    end
    test_reset();
    test_sparse();
    test_wrap_stop();
    test_trigger();
    test_arm_during_post();
    test_reset_armed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
